demux2_stream: RTL and testbench

- Registered 1-to-2 demultiplexer: the reverse direction of the 2:1 `select` mux.
- Accepts one input stream with a per-beat `in_sel` and steers each beat to output channel 0 or 1.
- Each output channel has a 2-entry buffer and a valid/ready handshake, so a stalled output does not block beats bound for the other channel.
- Sits between a single producer and two consumers in the lab datapath.

---
 rtl/demux2_stream.sv | 123 ++++++++++++
 tb/tb_demux2_stream.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - registered 1-to-2 stream demultiplexer with 2-entry per-channel buffers
module demux2_chan #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] head, tail;
  logic             pop;

  assign valid = (state != EMPTY);
  assign full  = (state == FULL);
  assign pop   = valid & ready;
  assign data  = head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (!push && pop) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // In ONE a simultaneous push/pop replaces the head rather than filling the tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: if (push) head <= push_data;
        ONE: begin
          if (push && pop) head <= push_data;
          else if (push)   tail <= push_data;
        end
        FULL:    if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (pop) cnt <= cnt + 1'b1;
  end

endmodule

module demux2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic full0, full1;
  logic push0, push1;

  // No pass-through: a FULL channel refuses even if it pops this same cycle.
  assign in_ready = in_sel ? !full1 : !full0;
  assign push0    = in_valid & in_ready & !in_sel;
  assign push1    = in_valid & in_ready & in_sel;

  demux2_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .ready     (out0_ready),
    .full      (full0),
    .valid     (out0_valid),
    .data      (out0_data),
    .cnt       (cnt0)
  );

  demux2_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .ready     (out1_ready),
    .full      (full1),
    .valid     (out1_valid),
    .data      (out1_data),
    .cnt       (cnt1)
  );

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - directed self-checking bench for demux2_stream
module tb_demux2_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_sel, in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out0_ready, out1_valid, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  demux2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    check_eq("idle_v0", out0_valid, 0);
    check_eq("idle_v1", out1_valid, 0);
    check_eq("idle_d0", out0_data, 0);
    check_eq("idle_d1", out1_data, 0);
    check_eq("idle_c0", cnt0, 0);
    check_eq("idle_c1", cnt1, 0);
    check_eq("idle_rdy", in_ready, 1);

    // single routes
    out0_ready = 1'b1; out1_ready = 1'b1;
    drive(1, 0, 8'hA5);
    tick();
    check_eq("r_v0", out0_valid, 1);
    check_eq("r_d0", out0_data, 8'hA5);
    check_eq("r_v1a", out1_valid, 0);
    drive(1, 1, 8'h3C);
    tick();
    check_eq("r_v0b", out0_valid, 0);
    check_eq("r_c0", cnt0, 1);
    check_eq("r_v1", out1_valid, 1);
    check_eq("r_d1", out1_data, 8'h3C);
    drive(0, 0, 8'h00);
    tick();
    check_eq("r_c1", cnt1, 1);
    check_eq("r_v1b", out1_valid, 0);

    // back-pressure fill on ch0
    out0_ready = 1'b0;
    drive(1, 0, 8'h11); tick();
    drive(1, 0, 8'h22); tick();
    drive(1, 0, 8'h33);
    check_eq("bp_rdy_full", in_ready, 0);
    tick();
    check_eq("bp_head", out0_data, 8'h11);
    check_eq("bp_hold_c0", cnt0, 1);
    out0_ready = 1'b1; #1;
    check_eq("bp_nopass", in_ready, 0);
    tick();
    check_eq("bp_pop1", out0_data, 8'h22);
    check_eq("bp_c0a", cnt0, 2);
    check_eq("bp_rdy_one", in_ready, 1);
    tick();
    check_eq("bp_pop2", out0_data, 8'h33);
    check_eq("bp_c0b", cnt0, 3);
    drive(0, 0, 8'h00);
    tick();
    check_eq("bp_c0c", cnt0, 4);
    check_eq("bp_empty", out0_valid, 0);

    // independent channels: ch0 full, ch1 flows
    out0_ready = 1'b0;
    drive(1, 0, 8'h44); tick();
    drive(1, 0, 8'h55); tick();
    out1_ready = 1'b1;
    drive(1, 1, 8'h77);
    check_eq("ind_rdy", in_ready, 1);
    tick();
    check_eq("ind_v1", out1_valid, 1);
    check_eq("ind_d1", out1_data, 8'h77);
    check_eq("ind_d0", out0_data, 8'h44);
    drive(0, 0, 8'h00);
    tick();
    check_eq("ind_c1", cnt1, 2);
    check_eq("ind_c0", cnt0, 4);
    check_eq("ind_v0", out0_valid, 1);
    drive(0, 1, 8'h00);
    check_eq("ind_sel1_rdy", in_ready, 1);

    // simultaneous push/pop on ch1
    out1_ready = 1'b0;
    drive(1, 1, 8'h01); tick();
    check_eq("pp_d1a", out1_data, 8'h01);
    out1_ready = 1'b1;
    drive(1, 1, 8'h02); tick();
    check_eq("pp_d1b", out1_data, 8'h02);
    check_eq("pp_v1", out1_valid, 1);
    check_eq("pp_c1", cnt1, 3);
    drive(0, 0, 8'h00);
    out1_ready = 1'b0;

    // drain ch0 (44,55) then wrap its counter
    out0_ready = 1'b1;
    tick(); tick();
    check_eq("w_c0_6", cnt0, 6);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'(8'h80 + i));
      tick();
    end
    check_eq("w_c0_15", cnt0, 15);
    check_eq("w_last", out0_data, 8'h89);
    drive(0, 0, 8'h00);
    tick();
    check_eq("w_c0_wrap", cnt0, 0);

    // fill ch1 then async reset between edges
    drive(1, 1, 8'hAA); tick();
    drive(1, 1, 8'hBB); tick();
    drive(0, 0, 8'h00);
    check_eq("ar_full", in_ready, 1);
    check_eq("ar_v1pre", out1_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_v1", out1_valid, 0);
    check_eq("ar_d1", out1_data, 0);
    check_eq("ar_c1", cnt1, 0);
    #1 rst = 1'b0;
    in_sel = 1'b1; #1;
    check_eq("ar_rdy", in_ready, 1);
    tick();
    check_eq("ar_v1post", out1_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
